multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle main control FSM for the 64-bit RISC-V datapath (regfile, ALU_64bit with ALU_CU, signextend, Data_Memory). It sequences one instruction at a time through fetch, decode, execute, memory and writeback. Each step drives the datapath mux selects, write enables and ALUOp. A single shared memory port serves both instruction and data, and every memory step waits on a ready handshake.

Parameters:
OPC_W, 7, opcode field width
ST_W, 4, state register width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  OPC_W  instruction bits [6:0], taken from the instruction register
Zero  in  1  ALU_64bit Zero flag
mem_ready  in  1  memory has completed the current read or write this cycle
PCWrite  out  1  load PC (unconditional OR (PCWriteCond AND Zero))
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load instruction register
MemtoReg  out  1  regfile write data select: 0 = ALUOut, 1 = MDR
RegWrite  out  1  regfile write enable
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs1 register
ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = const 4, 10 = imm, 11 = imm<<1
ALUOp  out  2  to ALU_CU: 00 = add, 01 = sub, 10 = funct
PCSource  out  1  PC input select: 0 = ALU result, 1 = ALUOut
illegal_instr  out  1  sticky unsupported-opcode flag
state_dbg  out  ST_W  current state, for debug

Behaviour:
- Moore FSM. All outputs decode combinationally from the state register, plus mem_ready (FETCH, MEM_RD, MEM_WR) and Zero (BRANCH only).
- Any output not listed for a state is 0.
- Reset: synchronous. On a clk edge with reset=1, state <= IDLE and illegal_instr <= 0. In IDLE all outputs are 0 and state_dbg = 0. Reset mid-instruction abandons that instruction at the next edge.
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7, R_WB 8, BRANCH 9, I_EXEC 10, I_WB 11, TRAP 12. Codes 13–15 go to IDLE.
- IDLE -> FETCH unconditionally.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0.
  - IRWrite and PCWrite equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precomputed into ALUOut). Dispatch on opcode:
  - 0110011 -> R_EXEC
  - 0000011 (ld) or 0100011 (sd) -> MEM_ADDR
  - 1100011 (beq) -> BRANCH
  - 0010011 (addi) -> I_EXEC
  - any other opcode -> TRAP
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_RD for ld, MEM_WR for sd.
- MEM_RD: IorD=1, MemRead=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: MemtoReg=1, RegWrite=1. Go to FETCH.
- MEM_WR: IorD=1, MemWrite=1. Hold until mem_ready, then go to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to R_WB.
- R_WB: MemtoReg=0, RegWrite=1. Go to FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to I_WB.
- I_WB: same outputs as R_WB. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=Zero. Go to FETCH.
- TRAP: illegal_instr <= 1 (sticky), all other outputs 0. Stays in TRAP until reset.
- Latency in cycles, counting from FETCH entry with zero-wait memory:
  - R-type and addi: 4
  - beq: 3
  - sd: 4
  - ld: 5
  - each mem_ready=0 cycle adds 1
- Requests are never dropped. MemRead/MemWrite stay asserted until mem_ready is seen; the state does not advance while mem_ready=0.
- MemRead and MemWrite are never high in the same cycle. RegWrite is never high in the same cycle as MemRead or MemWrite.

Decomposition:
- Shared package control_pkg holds:
  - state encodings
  - opcode constants: OP_RTYPE, OP_LD, OP_SD, OP_BEQ, OP_ADDI
  - ALUOp constants: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - ALUSrcB select constants
- One sub-module, opcode_decode: combinational, opcode -> one-hot instruction class {rtype, load, store, branch, itype, illegal}. Used by the DECODE and MEM_ADDR transitions.

Test Plan:
- Reset held 2 cycles, then released, mem_ready=1 -> state_dbg 0, 1, 2 on successive cycles. All outputs 0 while in IDLE. IRWrite=PCWrite=1 in FETCH.
- opcode=0110011, mem_ready=1 -> states 1, 2, 7, 8, 1. ALUOp=10 in R_EXEC. RegWrite=1, MemtoReg=0 only in R_WB.
- opcode=0000011, mem_ready low for 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles with MemRead=1, IorD=1 throughout, then MEM_WB with RegWrite=1, MemtoReg=1. Total 8 cycles.
- opcode=1100011:
  - Zero=1 -> PCWrite=1, PCSource=1, ALUOp=01 in BRANCH.
  - Zero=0 -> PCWrite=0.
  - Both cases: next state FETCH.
- opcode=1111111 -> TRAP after DECODE; illegal_instr=1 and held for 20 cycles. Reset clears it and returns to IDLE.
- Reset asserted during MEM_WR with mem_ready=0 -> next edge IDLE, MemWrite=0. After release, a new FETCH starts.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle RISC-V main control FSM:
// state encodings, opcode constants, ALU operation and ALU B-source selects.
package control_pkg;

   localparam int OPC_W_DEF = 7;
   localparam int ST_W_DEF  = 4;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_R_EXEC   = 4'd7,
      S_R_WB     = 4'd8,
      S_BRANCH   = 4'd9,
      S_I_EXEC   = 4'd10,
      S_I_WB     = 4'd11,
      S_TRAP     = 4'd12
   } state_t;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_SD    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_ADDI  = 7'b0010011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RS2    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH1 = 2'b11;

   // One-hot instruction class produced by opcode_decode.
   typedef struct packed {
      logic rtype;
      logic load;
      logic store;
      logic branch;
      logic itype;
      logic illegal;
   } instr_class_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: maps the 7-bit opcode to a one-hot class,
// with every unsupported encoding landing in the illegal class.
module opcode_decode
   import control_pkg::*;
#(
   parameter int OPC_W = OPC_W_DEF
) (
   input  logic [OPC_W-1:0] opcode,
   output instr_class_t     iclass
);

   // Classify the opcode; anything unrecognised is flagged illegal.
   always_comb begin
      iclass = '0;
      case (opcode)
         OP_RTYPE: iclass.rtype   = 1'b1;
         OP_LD:    iclass.load    = 1'b1;
         OP_SD:    iclass.store   = 1'b1;
         OP_BEQ:   iclass.branch  = 1'b1;
         OP_ADDI:  iclass.itype   = 1'b1;
         default:  iclass.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, enables and ALUOp from the current state.
module multicycle_control
   import control_pkg::*;
#(
   parameter int OPC_W = OPC_W_DEF,
   parameter int ST_W  = ST_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [OPC_W-1:0] opcode,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic             PCSource,
   output logic             illegal_instr,
   output logic [ST_W-1:0]  state_dbg
);

   state_t       state_r;
   state_t       next_state_s;
   logic         illegal_r;
   instr_class_t iclass_s;

   opcode_decode #(.OPC_W(OPC_W)) u_opcode_decode (
      .opcode (opcode),
      .iclass (iclass_s)
   );

   // State register with synchronous reset; reset abandons any instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Sticky illegal-instruction flag, raised on the edge that enters TRAP.
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_r <= 1'b0;
      end else if (next_state_s == S_TRAP) begin
         illegal_r <= 1'b1;
      end else begin
         illegal_r <= illegal_r;
      end
   end

   // Next-state and Moore output decode; memory steps hold until mem_ready.
   always_comb begin
      next_state_s = state_r;
      PCWrite      = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      MemtoReg     = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = SRCB_RS2;
      ALUOp        = ALUOP_ADD;
      PCSource     = 1'b0;

      case (state_r)
         S_IDLE: begin
            next_state_s = S_FETCH;
         end

         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) begin
               next_state_s = S_DECODE;
            end else begin
               next_state_s = S_FETCH;
            end
         end

         S_DECODE: begin
            // Branch target is precomputed into ALUOut here.
            ALUSrcB = SRCB_IMMSH1;
            if (iclass_s.rtype) begin
               next_state_s = S_R_EXEC;
            end else if (iclass_s.load || iclass_s.store) begin
               next_state_s = S_MEM_ADDR;
            end else if (iclass_s.branch) begin
               next_state_s = S_BRANCH;
            end else if (iclass_s.itype) begin
               next_state_s = S_I_EXEC;
            end else begin
               next_state_s = S_TRAP;
            end
         end

         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            if (iclass_s.load) begin
               next_state_s = S_MEM_RD;
            end else if (iclass_s.store) begin
               next_state_s = S_MEM_WR;
            end else begin
               next_state_s = S_TRAP;
            end
         end

         S_MEM_RD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            if (mem_ready) begin
               next_state_s = S_MEM_WB;
            end else begin
               next_state_s = S_MEM_RD;
            end
         end

         S_MEM_WB: begin
            MemtoReg     = 1'b1;
            RegWrite     = 1'b1;
            next_state_s = S_FETCH;
         end

         S_MEM_WR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) begin
               next_state_s = S_FETCH;
            end else begin
               next_state_s = S_MEM_WR;
            end
         end

         S_R_EXEC: begin
            ALUSrcA      = 1'b1;
            ALUSrcB      = SRCB_RS2;
            ALUOp        = ALUOP_FUNCT;
            next_state_s = S_R_WB;
         end

         S_R_WB, S_I_WB: begin
            RegWrite     = 1'b1;
            next_state_s = S_FETCH;
         end

         S_BRANCH: begin
            ALUSrcA      = 1'b1;
            ALUSrcB      = SRCB_RS2;
            ALUOp        = ALUOP_SUB;
            PCSource     = 1'b1;
            PCWrite      = Zero;
            next_state_s = S_FETCH;
         end

         S_I_EXEC: begin
            ALUSrcA      = 1'b1;
            ALUSrcB      = SRCB_IMM;
            next_state_s = S_I_WB;
         end

         S_TRAP: begin
            next_state_s = S_TRAP;
         end

         default: begin
            next_state_s = S_IDLE;
         end
      endcase
   end

   assign illegal_instr = illegal_r;
   assign state_dbg     = ST_W'(state_r);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised self-checking bench: builds each instruction's expected step list
// from its class and random memory waits, then checks state and outputs per cycle.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic       Zero;
   logic       mem_ready;
   logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite;
   logic       ALUSrcA, PCSource, illegal_instr;
   logic [1:0] ALUSrcB, ALUOp;
   logic [3:0] state_dbg;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] st;
      logic       mr;
      logic       z;
   } step_t;

   step_t q[$];

   multicycle_control dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .Zero          (Zero),
      .mem_ready     (mem_ready),
      .PCWrite       (PCWrite),
      .IorD          (IorD),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .IRWrite       (IRWrite),
      .MemtoReg      (MemtoReg),
      .RegWrite      (RegWrite),
      .ALUSrcA       (ALUSrcA),
      .ALUSrcB       (ALUSrcB),
      .ALUOp         (ALUOp),
      .PCSource      (PCSource),
      .illegal_instr (illegal_instr),
      .state_dbg     (state_dbg)
   );

   always #5 clk = ~clk;

   // Expected output bundle straight from the per-state table:
   // {PCWrite,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
   function automatic logic [12:0] exp_out(input logic [3:0] st, input logic mr, input logic z);
      case (st)
         4'd1:    return {mr, 1'b0, 1'b1, 1'b0, mr, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0};
         4'd2:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0};
         4'd3:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0};
         4'd4:    return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
         4'd5:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
         4'd6:    return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
         4'd7:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0};
         4'd8:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
         4'd9:    return {z,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1};
         4'd10:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0};
         4'd11:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
         default: return 13'd0;
      endcase
   endfunction

   function automatic logic [12:0] obs_out();
      return {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
              ALUSrcA, ALUSrcB, ALUOp, PCSource};
   endfunction

   task automatic check_now(input string tag, input logic [3:0] est, input logic [12:0] eo,
                            input logic eill);
      checks++;
      assert (state_dbg === est) else begin
         failures++;
         $error("FAIL %s state observed=%0d expected=%0d", tag, state_dbg, est);
      end
      checks++;
      assert (obs_out() === eo) else begin
         failures++;
         $error("FAIL %s outputs observed=%b expected=%b (state %0d)", tag, obs_out(), eo, est);
      end
      checks++;
      assert (illegal_instr === eill) else begin
         failures++;
         $error("FAIL %s illegal_instr observed=%b expected=%b", tag, illegal_instr, eill);
      end
   endtask

   // Append a phase; memory phases wait 'waits' cycles with mem_ready low first.
   task automatic push_phase(input logic [3:0] st, input bit is_mem, input int waits, input logic z);
      step_t s;
      if (is_mem) begin
         for (int i = 0; i < waits; i++) begin
            s.st = st; s.mr = 1'b0; s.z = 1'($urandom_range(1, 0));
            q.push_back(s);
         end
         s.st = st; s.mr = 1'b1; s.z = 1'($urandom_range(1, 0));
      end else begin
         s.st = st; s.mr = 1'($urandom_range(1, 0));
         s.z  = (st == 4'd9) ? z : 1'($urandom_range(1, 0));
      end
      q.push_back(s);
   endtask

   // Build and play one instruction from FETCH; waits<0 picks random wait counts.
   task automatic run_instr(input string tag, input logic [6:0] op, input int waits,
                            input logic z);
      int base;
      int wf, wm;
      wf = (waits < 0) ? int'($urandom_range(2, 0)) : 0;
      wm = (waits < 0) ? int'($urandom_range(3, 0)) : waits;
      q.delete();
      push_phase(4'd1, 1'b1, wf, z);
      push_phase(4'd2, 1'b0, 0, z);
      case (op)
         7'b0110011: begin push_phase(4'd7, 1'b0, 0, z); push_phase(4'd8, 1'b0, 0, z); base = 4; end
         7'b0010011: begin push_phase(4'd10, 1'b0, 0, z); push_phase(4'd11, 1'b0, 0, z); base = 4; end
         7'b1100011: begin push_phase(4'd9, 1'b0, 0, z); base = 3; end
         7'b0100011: begin push_phase(4'd3, 1'b0, 0, z); push_phase(4'd6, 1'b1, wm, z); base = 4; end
         7'b0000011: begin
            push_phase(4'd3, 1'b0, 0, z); push_phase(4'd4, 1'b1, wm, z);
            push_phase(4'd5, 1'b0, 0, z); base = 5;
         end
         default: base = 0;
      endcase
      checks++;
      assert (q.size() == base + wf + ((op == 7'b0000011 || op == 7'b0100011) ? wm : 0)) else begin
         failures++;
         $error("FAIL %s latency observed=%0d expected=%0d", tag, q.size(), base + wf + wm);
      end
      foreach (q[i]) begin
         @(negedge clk);
         opcode    = op;
         mem_ready = q[i].mr;
         Zero      = q[i].z;
         #1;
         check_now(tag, q[i].st, exp_out(q[i].st, q[i].mr, q[i].z), 1'b0);
      end
   endtask

   initial begin
      logic [6:0] ops [5];
      ops[0] = 7'b0110011; ops[1] = 7'b0000011; ops[2] = 7'b0100011;
      ops[3] = 7'b1100011; ops[4] = 7'b0010011;

      reset = 1'b1; opcode = 7'b0110011; Zero = 1'b0; mem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         check_now("reset_hold", 4'd0, 13'd0, 1'b0);
      end
      reset = 1'b0;
      #1;
      check_now("idle_after_release", 4'd0, 13'd0, 1'b0);

      run_instr("rtype", 7'b0110011, 0, 1'b0);
      run_instr("ld_wait3", 7'b0000011, 3, 1'b0);
      run_instr("beq_taken", 7'b1100011, 0, 1'b1);
      run_instr("beq_not_taken", 7'b1100011, 0, 1'b0);
      run_instr("addi", 7'b0010011, 0, 1'b0);
      run_instr("sd", 7'b0100011, 2, 1'b0);

      for (int n = 0; n < 40; n++) begin
         logic [6:0] op;
         op = ops[$urandom_range(4, 0)];
         run_instr("random", op, -1, 1'($urandom_range(1, 0)));
      end

      // Unsupported opcode: DECODE then TRAP, flag sticky for 20 cycles.
      @(negedge clk); opcode = 7'b1111111; mem_ready = 1'b1; #1;
      check_now("trap_fetch", 4'd1, exp_out(4'd1, 1'b1, Zero), 1'b0);
      @(negedge clk); #1;
      check_now("trap_decode", 4'd2, exp_out(4'd2, 1'b0, 1'b0), 1'b0);
      @(negedge clk); #1;
      checks++;
      assert (state_dbg === 4'd12) else begin
         failures++;
         $error("FAIL trap_entry state observed=%0d expected=12", state_dbg);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         mem_ready = 1'($urandom_range(1, 0)); opcode = 7'($urandom);
         #1;
         check_now("trap_hold", 4'd12, 13'd0, 1'b1);
      end
      reset = 1'b1;
      @(negedge clk); #1;
      check_now("trap_reset", 4'd0, 13'd0, 1'b0);
      reset = 1'b0;

      // Reset while a store is stalled in MEM_WR.
      opcode = 7'b0100011;
      @(negedge clk); mem_ready = 1'b1; #1;
      check_now("rst_sd_fetch", 4'd1, exp_out(4'd1, 1'b1, Zero), 1'b0);
      @(negedge clk); #1;
      check_now("rst_sd_decode", 4'd2, exp_out(4'd2, 1'b0, 1'b0), 1'b0);
      @(negedge clk); #1;
      check_now("rst_sd_addr", 4'd3, exp_out(4'd3, 1'b0, 1'b0), 1'b0);
      @(negedge clk); mem_ready = 1'b0; #1;
      check_now("rst_sd_memwr", 4'd6, exp_out(4'd6, 1'b0, 1'b0), 1'b0);
      reset = 1'b1;
      @(negedge clk); #1;
      check_now("rst_sd_idle", 4'd0, 13'd0, 1'b0);
      reset = 1'b0; mem_ready = 1'b1;
      @(negedge clk); #1;
      check_now("rst_sd_refetch", 4'd1, exp_out(4'd1, 1'b1, Zero), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
